// File: rtl/exe_commit_arb.sv
// Commit collector: round-robin grant of one execute unit per cycle into a registered ROB write slot.
// Latency 1 cycle (grant edge -> rob_wb_valid); backpressure: a full, unpopped slot zeroes every cs_allowin.
// Optional COMMIT_ARB_PERF_EN adds perf_conflict_cnt (cycles with two or more units contending, outside flush).
package exe_commit_arb_pkg;
    typedef struct packed {
        logic       ex;
        logic [4:0] exccode;
    } exception_t;

    localparam logic [4:0] EXC_OV = 5'h0c;

    typedef struct packed {
        logic [5:0]  rob_entry_num;
        logic        rf_we;
        logic [5:0]  phy_dest;
        logic [31:0] result;
        exception_t  exception;
    } execute_to_commit_bus_t;
endpackage

module exe_commit_arb
    import exe_commit_arb_pkg::*;
#(
    parameter int N_FU = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [N_FU-1:0]                   fu_to_valid,
    input  execute_to_commit_bus_t [N_FU-1:0] fu_to_commit_bus,
    output logic [N_FU-1:0]                   cs_allowin,
    output logic                              rob_wb_valid,
    input  logic                              rob_wb_ready,
    output execute_to_commit_bus_t            rob_wb_bus
`ifdef COMMIT_ARB_PERF_EN
    ,
    output logic [31:0]                       perf_conflict_cnt
`endif
);
    localparam int PTR_W = $clog2(N_FU);

    logic                   out_valid_q, out_valid_d;
    execute_to_commit_bus_t out_bus_q, out_bus_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       win;
    logic                   found;
    logic                   pop, slot_free, push;

    // First requester at or after rr_ptr, wrapping past N_FU-1 back to 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N_FU; k++) begin
            if (!found && fu_to_valid[(int'(rr_ptr_q) + k) % N_FU]) begin
                found = 1'b1;
                win   = PTR_W'((int'(rr_ptr_q) + k) % N_FU);
            end
        end
    end

    assign pop       = out_valid_q & rob_wb_ready;
    assign slot_free = !out_valid_q | pop;

    always_comb begin
        cs_allowin = '0;
        if (found && slot_free && !flush && !reset) begin
            cs_allowin[win] = 1'b1;
        end
    end

    assign push = |cs_allowin;

    // Payload is copied only on a grant, so X on idle units never reaches the slot.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bus_d   = out_bus_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (push) begin
            out_valid_d = 1'b1;
            out_bus_d   = fu_to_commit_bus[win];
            rr_ptr_d    = (win == PTR_W'(N_FU - 1)) ? '0 : PTR_W'(win + 1'b1);
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_bus_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_bus_q   <= out_bus_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rob_wb_valid = out_valid_q;
    assign rob_wb_bus   = out_bus_q;

`ifdef COMMIT_ARB_PERF_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt_q <= '0;
        end else if (!flush && ($countones(fu_to_valid) >= 2)) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_conflict_cnt = perf_cnt_q;
`endif
endmodule
